// File: rtl/video_timing_pkg.sv
// Shared raster-timing types, standard mode constants and elaboration helpers.
package video_timing_pkg;

  typedef struct packed {
    int unsigned h_active, h_fp, h_sync, h_bp;
    int unsigned v_active, v_fp, v_sync, v_bp;
  } vt_mode_t;

  localparam vt_mode_t VGA_640x480  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vt_mode_t SVGA_800x600 = '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vt_mode_t HD_1280x720  = '{1280, 110, 40, 220, 720, 5, 5, 20};

  function automatic int unsigned vt_total(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned vt_clog2(input int unsigned n);
    int unsigned r = 0;
    if (n > 1)
      for (int unsigned v = n - 1; v > 0; v >>= 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: enabled counter wrapping at TOTAL-1, exposing its next state and a wrap flag.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned CW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_wrap_nxt,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  always_comb begin
    o_wrap_nxt = i_en && (o_cnt == LAST);
    o_cnt_nxt  = o_cnt;
    if (i_en) o_cnt_nxt = o_wrap_nxt ? '0 : o_cnt + 1'b1;
  end

  // Reset parks on the last position so the first enable wraps into 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cnt  <= LAST;
      o_wrap <= 1'b0;
    end else begin
      o_cnt  <= o_cnt_nxt;
      o_wrap <= o_wrap_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator. Optional o_frame_cnt with VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_active_end
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,output logic [15:0]  o_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam logic [CW-1:0] AE_X  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] AE_Y  = CW'(V_ACTIVE - 1);

  if (vt_clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) > CW) begin : g_cw_check
    $fatal(1, "video_timing_gen: CW=%0d cannot hold the raster totals", CW);
  end

  logic [CW-1:0] x_nxt, y_nxt;
  logic          h_wrap_nxt, v_wrap_nxt, h_wrap, v_wrap;
  logic          de_nxt, hs_on, vs_on, ae_nxt;

  video_timing_axis #(.TOTAL(H_TOTAL), .CW(CW)) u_h (
    .i_clk, .i_rst_n, .i_en(i_pix_stb),
    .o_cnt(o_x), .o_cnt_nxt(x_nxt), .o_wrap_nxt(h_wrap_nxt), .o_wrap(h_wrap)
  );

  video_timing_axis #(.TOTAL(V_TOTAL), .CW(CW)) u_v (
    .i_clk, .i_rst_n, .i_en(h_wrap_nxt),
    .o_cnt(o_y), .o_cnt_nxt(y_nxt), .o_wrap_nxt(v_wrap_nxt), .o_wrap(v_wrap)
  );

  // The axis wrap flags are exactly the entry pulses for x==0 and (0,0).
  assign o_line_start  = h_wrap;
  assign o_frame_start = v_wrap;

  always_comb begin
    de_nxt = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
    hs_on  = (32'(x_nxt) >= HS_BEG) && (32'(x_nxt) < HS_END);
    vs_on  = (32'(y_nxt) >= VS_BEG) && (32'(y_nxt) < VS_END);
    ae_nxt = i_pix_stb && (x_nxt == AE_X) && (y_nxt == AE_Y);
  end

  // Decoding the next state keeps every level output aligned with o_x/o_y.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_de         <= 1'b0;
      o_hs         <= ~HS_POL;
      o_vs         <= ~VS_POL;
      o_active_end <= 1'b0;
    end else begin
      o_de         <= de_nxt;
      o_hs         <= hs_on ? HS_POL : ~HS_POL;
      o_vs         <= vs_on ? VS_POL : ~VS_POL;
      o_active_end <= ae_nxt;
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                     o_frame_cnt <= '0;
    else if (h_wrap_nxt && v_wrap_nxt) o_frame_cnt <= o_frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: VGA, HD (active-high syncs) and a tiny mode checked against a per-cycle reference.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, stb = 1'b0;
  int nchk = 0, nerr = 0;

  logic [9:0]  vga_x, vga_y;
  logic [10:0] hd_x, hd_y;
  logic [3:0]  sm_x, sm_y;
  logic vga_hs, vga_vs, vga_de, vga_ls, vga_fs, vga_ae;
  logic hd_hs, hd_vs, hd_de, hd_ls, hd_fs, hd_ae;
  logic sm_hs, sm_vs, sm_de, sm_ls, sm_fs, sm_ae;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] vga_fc, hd_fc, sm_fc;
`endif

  video_timing_gen u_vga (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .o_hs(vga_hs), .o_vs(vga_vs), .o_de(vga_de),
    .o_x(vga_x), .o_y(vga_y), .o_line_start(vga_ls), .o_frame_start(vga_fs), .o_active_end(vga_ae)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(vga_fc)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(HD_1280x720.h_active), .H_FP(HD_1280x720.h_fp), .H_SYNC(HD_1280x720.h_sync),
    .H_BP(HD_1280x720.h_bp), .V_ACTIVE(HD_1280x720.v_active), .V_FP(HD_1280x720.v_fp),
    .V_SYNC(HD_1280x720.v_sync), .V_BP(HD_1280x720.v_bp), .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) u_hd (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .o_hs(hd_hs), .o_vs(hd_vs), .o_de(hd_de),
    .o_x(hd_x), .o_y(hd_y), .o_line_start(hd_ls), .o_frame_start(hd_fs), .o_active_end(hd_ae)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(hd_fc)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
  ) u_sm (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .o_hs(sm_hs), .o_vs(sm_vs), .o_de(sm_de),
    .o_x(sm_x), .o_y(sm_y), .o_line_start(sm_ls), .o_frame_start(sm_fs), .o_active_end(sm_ae)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(sm_fc)
`endif
  );

  // Reference model timing tables: index 0 = VGA, 1 = HD, 2 = small mode.
  int ha[3] = '{640, 1280, 8};
  int hf[3] = '{16, 110, 2};
  int hy[3] = '{96, 40, 3};
  int hb[3] = '{48, 220, 2};
  int va[3] = '{480, 720, 4};
  int vf[3] = '{10, 5, 1};
  int vy[3] = '{2, 5, 2};
  int vb[3] = '{33, 20, 1};
  bit hp[3] = '{1'b0, 1'b1, 1'b1};
  bit vp[3] = '{1'b0, 1'b1, 1'b0};
  int mx[3], my[3], mfc[3];
  bit mls[3], mfs[3], mae[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s);
    for (int d = 0; d < 3; d++) begin
      int ht, vt;
      ht = ha[d] + hf[d] + hy[d] + hb[d];
      vt = va[d] + vf[d] + vy[d] + vb[d];
      mls[d] = 0; mfs[d] = 0; mae[d] = 0;
      if (!r) begin
        mx[d] = ht - 1; my[d] = vt - 1; mfc[d] = 0;
      end else if (s) begin
        if (mx[d] == ht - 1) begin
          mx[d] = 0;
          my[d] = (my[d] == vt - 1) ? 0 : my[d] + 1;
        end else mx[d]++;
        mls[d] = (mx[d] == 0);
        mfs[d] = (mx[d] == 0) && (my[d] == 0);
        mae[d] = (mx[d] == ha[d] - 1) && (my[d] == va[d] - 1);
        if (mfs[d]) mfc[d] = (mfc[d] + 1) % 65536;
      end
    end
  endtask

  task automatic chk_dut(input string nm, input int d, input int x, input int y, input logic [5:0] f);
    bit de, hs, vs;
    de = (mx[d] < ha[d]) && (my[d] < va[d]);
    hs = (mx[d] >= ha[d] + hf[d] && mx[d] < ha[d] + hf[d] + hy[d]) ? hp[d] : !hp[d];
    vs = (my[d] >= va[d] + vf[d] && my[d] < va[d] + vf[d] + vy[d]) ? vp[d] : !vp[d];
    chk({nm, "_xy"}, x * 4096 + y, mx[d] * 4096 + my[d]);
    chk({nm, "_flags"}, {26'd0, f}, {26'd0, de, hs, vs, mls[d], mfs[d], mae[d]});
  endtask

  task automatic step(input bit r, input bit s);
    rst_n = r; stb = s;
    @(posedge clk);
    model_step(r, s);
    #1;
    chk_dut("vga", 0, int'(vga_x), int'(vga_y), {vga_de, vga_hs, vga_vs, vga_ls, vga_fs, vga_ae});
    chk_dut("hd", 1, int'(hd_x), int'(hd_y), {hd_de, hd_hs, hd_vs, hd_ls, hd_fs, hd_ae});
    chk_dut("sm", 2, int'(sm_x), int'(sm_y), {sm_de, sm_hs, sm_vs, sm_ls, sm_fs, sm_ae});
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    chk("vga_fcnt", {16'd0, vga_fc}, mfc[0]);
    chk("hd_fcnt", {16'd0, hd_fc}, mfc[1]);
    chk("sm_fcnt", {16'd0, sm_fc}, mfc[2]);
`endif
  endtask

  typedef struct {
    bit r, s;
    int x, y;
    logic [5:0] f;   // {de, hs, vs, line_start, frame_start, active_end}
  } vec_t;
  vec_t vt[8];

  initial begin
    int hs_cnt, hs_first, hs_last, x799, n, ls_cnt, de_cnt, vs_cnt, fs_cnt, ae_cnt;

    vt[0] = '{0, 1, 799, 524, 6'b011000};
    vt[1] = '{1, 0, 799, 524, 6'b011000};
    vt[2] = '{1, 1, 0, 0, 6'b111110};
    vt[3] = '{1, 0, 0, 0, 6'b111000};
    vt[4] = '{1, 1, 1, 0, 6'b111000};
    vt[5] = '{1, 1, 2, 0, 6'b111000};
    vt[6] = '{0, 0, 799, 524, 6'b011000};
    vt[7] = '{1, 1, 0, 0, 6'b111110};

    // Hand-computed VGA vectors covering reset, hold, first strobe and reset priority.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].r, vt[i].s);
      chk($sformatf("vec%0d_x", i), vga_x, vt[i].x);
      chk($sformatf("vec%0d_y", i), vga_y, vt[i].y);
      chk($sformatf("vec%0d_flags", i), {26'd0, vga_de, vga_hs, vga_vs, vga_ls, vga_fs, vga_ae},
          {26'd0, vt[i].f});
    end

    // One full VGA line from (0,0): hsync window and wrap into line 1.
    hs_cnt = 0; hs_first = -1; hs_last = -1; x799 = -1;
    for (int i = 1; i <= 800; i++) begin
      step(1, 1);
      if (vga_hs == 1'b0) begin
        if (hs_cnt == 0) hs_first = int'(vga_x);
        hs_last = int'(vga_x);
        hs_cnt++;
      end
      if (i == 799) x799 = int'(vga_x);
    end
    chk("vga_hs_width", hs_cnt, 96);
    chk("vga_hs_first", hs_first, 656);
    chk("vga_hs_last", hs_last, 751);
    chk("vga_x_before_wrap", x799, 799);
    chk("vga_wrap_xy", {vga_x, 12'd0, vga_y}, {10'd0, 12'd0, 10'd1});
    chk("vga_wrap_ls", vga_ls, 1);

    // Reset at (300,1) with strobe high, then restart.
    for (int i = 0; i < 300; i++) step(1, 1);
    chk("vga_at_300", vga_x, 300);
    step(0, 1);
    chk("rst_mid_xy", {vga_x, 12'd0, vga_y}, {10'd799, 12'd0, 10'd524});
    chk("rst_mid_flags", {vga_de, vga_ls, vga_fs, vga_ae}, 0);
    step(1, 1);
    chk("rst_mid_restart", {vga_x, vga_y, vga_fs}, {20'd0, 1'b1});

    // Small mode: three back-to-back frames.
    step(0, 0);
    ls_cnt = 0; fs_cnt = 0; ae_cnt = 0; de_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 360; i++) begin
      step(1, 1);
      ls_cnt += sm_ls; fs_cnt += sm_fs; ae_cnt += sm_ae; de_cnt += sm_de;
      vs_cnt += (sm_vs == 1'b0);
    end
    chk("sm_line_starts", ls_cnt, 24);
    chk("sm_frame_starts", fs_cnt, 3);
    chk("sm_active_ends", ae_cnt, 3);
    chk("sm_de_pixels", de_cnt, 96);
    chk("sm_vs_pixels", vs_cnt, 90);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    chk("sm_fcnt_3", sm_fc, 3);
`endif

    // Small mode: strobe one clock in four for one frame; pulses stay 1 clk wide.
    ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 480; i++) begin
      step(1, (i % 4) == 3);
      ls_cnt += sm_ls; fs_cnt += sm_fs;
    end
    chk("sm_div4_line_starts", ls_cnt, 8);
    chk("sm_div4_frame_starts", fs_cnt, 1);

    // HD: reset position, then measure one line length and active-high hsync.
    step(0, 0);
    chk("hd_rst_xy", {hd_x, 1'b0, hd_y}, {11'd1649, 1'b0, 11'd749});
    chk("hd_rst_sync", {hd_hs, hd_vs}, 0);
    n = 0; ls_cnt = 0; hs_cnt = 0; hs_first = -1;
    while (ls_cnt < 2 && n < 4000) begin
      step(1, 1);
      n++;
      if (hd_ls) ls_cnt++;
      if (ls_cnt == 1 && hd_hs) begin
        if (hs_cnt == 0) hs_first = int'(hd_x);
        hs_cnt++;
      end
    end
    chk("hd_h_total", n - 1, 1650);
    chk("hd_hs_width", hs_cnt, 40);
    chk("hd_hs_first", hs_first, 1390);
    chk("hd_line1_y", hd_y, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
